// File: rtl/reg_writeback_queue.sv
// Write-back queue for the 8-bit x 16 register bank: in-order FIFO, one retire per cycle,
// and a lookup port for values still pending. Define WB_COALESCE_EN to merge same-register writes.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_reg,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         hold,
  output logic                         EscReg,
  output logic [ADDR_W-1:0]            RegEscrito,
  output logic [DATA_W-1:0]            DadoEscrito,
  input  logic [ADDR_W-1:0]            lookup_reg,
  output logic                         lookup_hit,
  output logic [DATA_W-1:0]            lookup_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] regAddr [DEPTH];
  logic [DATA_W-1:0] regData [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;

  logic doPush;
  logic doPop;
  logic allocPush;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign doPush   = in_valid && in_ready;
  // A push into an empty queue is never popped on the same edge: doPop looks at the old count.
  assign doPop    = (count != '0) && !hold;

`ifdef WB_COALESCE_EN
  logic              matchFound;
  logic              matchAtHead;
  logic [PTR_W-1:0]  matchIdx;
  logic              coalesce;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    matchFound  = 1'b0;
    matchAtHead = 1'b0;
    matchIdx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count && regAddr[headPtr + PTR_W'(k)] == in_reg) begin
        matchFound  = 1'b1;
        matchAtHead = (k == 0);
        matchIdx    = headPtr + PTR_W'(k);
      end
    end
  end

  // Merging into the head that is leaving this edge would lose the write, so allocate instead.
  assign coalesce  = doPush && matchFound && !(doPop && matchAtHead);
  assign allocPush = doPush && !coalesce;
`else
  assign allocPush = doPush;
`endif

  // NOTE: the entry storage has no reset; occupancy (count) alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (allocPush) begin
      regAddr[tailPtr] <= in_reg;
      regData[tailPtr] <= in_data;
    end
`ifdef WB_COALESCE_EN
    else if (coalesce) begin
      regData[matchIdx] <= in_data;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      headPtr     <= '0;
      tailPtr     <= '0;
      count       <= '0;
      EscReg      <= 1'b0;
      RegEscrito  <= '0;
      DadoEscrito <= '0;
    end else begin
      EscReg <= doPop;
      if (doPop) begin
        RegEscrito  <= regAddr[headPtr];
        DadoEscrito <= regData[headPtr];
        headPtr     <= headPtr + 1'b1;
      end
      if (allocPush) begin
        tailPtr <= tailPtr + 1'b1;
      end
      unique case ({allocPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  logic              fifoHit;
  logic [DATA_W-1:0] fifoData;
  logic              stageHit;

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fifoHit  = 1'b0;
    fifoData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count && regAddr[headPtr + PTR_W'(k)] == lookup_reg) begin
        fifoHit  = 1'b1;
        fifoData = regData[headPtr + PTR_W'(k)];
      end
    end
  end

  assign stageHit    = EscReg && (RegEscrito == lookup_reg);
  assign lookup_hit  = fifoHit || stageHit;
  assign lookup_data = fifoHit  ? fifoData :
                       stageHit ? DadoEscrito : '0;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_reg_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DEPTH+1);
`ifdef WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              hold;
  logic              EscReg;
  logic [ADDR_W-1:0] RegEscrito;
  logic [DATA_W-1:0] DadoEscrito;
  logic [ADDR_W-1:0] lookup_reg;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic [CNT_W-1:0]  count;

  reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .hold(hold),
    .EscReg(EscReg), .RegEscrito(RegEscrito), .DadoEscrito(DadoEscrito),
    .lookup_reg(lookup_reg), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .count(count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes plus the last retired write.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t            mq[$];
  bit                mEsc = 1'b0;
  logic [ADDR_W-1:0] mReg = '0;
  logic [DATA_W-1:0] mDat = '0;

  task automatic modelStep(input bit rst, input bit v, input logic [ADDR_W-1:0] r,
                           input logic [DATA_W-1:0] d, input bit h);
    bit     ready;
    bit     push;
    bit     pop;
    bit     merged;
    entry_t head;
    entry_t ne;
    if (rst) begin
      mq.delete();
      mEsc = 1'b0;
      mReg = '0;
      mDat = '0;
    end else begin
      ready  = mq.size() < DEPTH;
      push   = v && ready;
      pop    = (mq.size() > 0) && !h;
      merged = 1'b0;
      mEsc   = pop;
      if (pop) begin
        head = mq.pop_front();
        mReg = head.a;
        mDat = head.d;
      end
      if (push) begin
`ifdef WB_COALESCE_EN
        foreach (mq[i]) begin
          if (mq[i].a == r) begin
            mq[i].d = d;
            merged  = 1'b1;
          end
        end
`endif
        if (!merged) begin
          ne.a = r;
          ne.d = d;
          mq.push_back(ne);
        end
      end
    end
  endtask

  function automatic logic [DATA_W:0] modelLookup(input logic [ADDR_W-1:0] lr);
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == lr) return {1'b1, mq[i].d};
    end
    if (mEsc && mReg == lr) return {1'b1, mDat};
    return '0;
  endfunction

  task automatic compareAll(input logic [ADDR_W-1:0] lr);
    logic [DATA_W:0] lk;
    lk = modelLookup(lr);
    check("EscReg",      32'(EscReg),      32'(mEsc));
    check("RegEscrito",  32'(RegEscrito),  32'(mReg));
    check("DadoEscrito", 32'(DadoEscrito), 32'(mDat));
    check("count",       32'(count),       32'(mq.size()));
    check("in_ready",    32'(in_ready),    32'(mq.size() < DEPTH));
    check("lookup_hit",  32'(lookup_hit),  32'(lk[DATA_W]));
    check("lookup_data", 32'(lookup_data), 32'(lk[DATA_W-1:0]));
  endtask

  // Apply one cycle of inputs, advance past the edge, compare against the model.
  task automatic drive(input bit rst, input bit v, input logic [ADDR_W-1:0] r,
                       input logic [DATA_W-1:0] d, input bit h, input logic [ADDR_W-1:0] lr);
    reset      = rst;
    in_valid   = v;
    in_reg     = r;
    in_data    = d;
    hold       = h;
    lookup_reg = lr;
    modelStep(rst, v, r, d, h);
    @(posedge clock);
    #1;
    compareAll(lr);
  endtask

  typedef struct {
    bit                rst;
    bit                v;
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
    bit                h;
    logic [ADDR_W-1:0] lr;
    bit                eEsc;
    logic [ADDR_W-1:0] eReg;
    logic [DATA_W-1:0] eDat;
    int                eCnt;
    bit                eRdy;
    bit                eHit;
    logic [DATA_W-1:0] eLd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; hold = 1'b0; lookup_reg = '0;

    //            rst v  r  d      h  lr   esc    reg dat                cnt             rdy hit    ldata
    vecs[0]  = '{1, 0, 0, 8'h00, 0, 0,   0,     0, 8'h00,             0,              1,  0,     8'h00};
    vecs[1]  = '{0, 1, 3, 8'h5A, 0, 3,   0,     0, 8'h00,             1,              1,  1,     8'h5A};
    vecs[2]  = '{0, 0, 0, 8'h00, 0, 3,   1,     3, 8'h5A,             0,              1,  1,     8'h5A};
    vecs[3]  = '{0, 0, 0, 8'h00, 0, 3,   0,     3, 8'h5A,             0,              1,  0,     8'h00};
    vecs[4]  = '{0, 1, 7, 8'h10, 1, 7,   0,     3, 8'h5A,             1,              1,  1,     8'h10};
    vecs[5]  = '{0, 1, 7, 8'h20, 1, 7,   0,     3, 8'h5A,             COAL ? 1 : 2,   1,  1,     8'h20};
    vecs[6]  = '{0, 0, 0, 8'h00, 0, 7,   1,     7, COAL ? 8'h20 : 8'h10, COAL ? 0 : 1, 1, 1,     8'h20};
    vecs[7]  = '{0, 0, 0, 8'h00, 0, 7,   !COAL, 7, 8'h20,             0,              1,  !COAL, COAL ? 8'h00 : 8'h20};
    vecs[8]  = '{0, 0, 0, 8'h00, 0, 7,   0,     7, 8'h20,             0,              1,  0,     8'h00};
    vecs[9]  = '{0, 1, 9, 8'h99, 0, 9,   0,     7, 8'h20,             1,              1,  1,     8'h99};
    vecs[10] = '{0, 0, 0, 8'h00, 0, 9,   1,     9, 8'h99,             0,              1,  1,     8'h99};
    vecs[11] = '{0, 0, 0, 8'h00, 0, 9,   0,     9, 8'h99,             0,              1,  0,     8'h00};
    vecs[12] = '{0, 1, 0, 8'hA5, 0, 0,   0,     9, 8'h99,             1,              1,  1,     8'hA5};
    vecs[13] = '{0, 0, 0, 8'h00, 0, 0,   1,     0, 8'hA5,             0,              1,  1,     8'hA5};

    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; in_valid = vecs[i].v; in_reg = vecs[i].r; in_data = vecs[i].d;
      hold = vecs[i].h; lookup_reg = vecs[i].lr;
      modelStep(vecs[i].rst, vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].h);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d.EscReg", i),      32'(EscReg),      32'(vecs[i].eEsc));
      check($sformatf("vec%0d.RegEscrito", i),  32'(RegEscrito),  32'(vecs[i].eReg));
      check($sformatf("vec%0d.DadoEscrito", i), 32'(DadoEscrito), 32'(vecs[i].eDat));
      check($sformatf("vec%0d.count", i),       32'(count),       32'(vecs[i].eCnt));
      check($sformatf("vec%0d.in_ready", i),    32'(in_ready),    32'(vecs[i].eRdy));
      check($sformatf("vec%0d.lookup_hit", i),  32'(lookup_hit),  32'(vecs[i].eHit));
      check($sformatf("vec%0d.lookup_data", i), 32'(lookup_data), 32'(vecs[i].eLd));
    end
    drive(0, 0, 0, 8'h00, 0, 0);

    // Fill under hold, reject a fifth push, then drain in order.
    for (int i = 1; i <= 4; i++) drive(0, 1, ADDR_W'(i), 8'(i * 17), 1, 0);
    check("fill.count", 32'(count), 32'd4);
    check("fill.in_ready", 32'(in_ready), 32'd0);
    drive(0, 1, 4'd5, 8'h55, 1, 5);
    check("full.count", 32'(count), 32'd4);
    check("full.lookup_hit_r5", 32'(lookup_hit), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 8'h00, 0, 0);
      check($sformatf("drain%0d.EscReg", k), 32'(EscReg), 32'd1);
      check($sformatf("drain%0d.RegEscrito", k), 32'(RegEscrito), 32'(k + 1));
      check($sformatf("drain%0d.DadoEscrito", k), 32'(DadoEscrito), 32'((k + 1) * 17));
    end
    check("drain.count", 32'(count), 32'd0);
    drive(0, 0, 0, 8'h00, 0, 0);
    check("drain.idle_EscReg", 32'(EscReg), 32'd0);

    // Full with hold released and a push waiting: refused this edge, accepted the next.
    for (int i = 1; i <= 4; i++) drive(0, 1, ADDR_W'(i), 8'(i + 8'h40), 1, 0);
    check("full2.in_ready_before", 32'(in_ready), 32'd0);
    drive(0, 1, 4'd6, 8'h66, 0, 6);
    check("full2.count_after_pop", 32'(count), 32'd3);
    check("full2.in_ready_after", 32'(in_ready), 32'd1);
    check("full2.not_accepted", 32'(lookup_hit), 32'd0);
    drive(0, 1, 4'd6, 8'h66, 0, 6);
    check("full2.count_push_pop", 32'(count), 32'd3);
    check("full2.accepted_hit", 32'(lookup_hit), 32'd1);
    check("full2.accepted_data", 32'(lookup_data), 32'h66);

    // Streaming across several pointer wraps.
    for (int i = 0; i < 3 * DEPTH; i++) drive(0, 1, ADDR_W'(i), 8'($urandom), 0, ADDR_W'(i));
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, 0, 8'h00, 0, 0);

    // Reset while entries are pending and one is retiring: nothing further may retire.
    for (int i = 1; i <= 4; i++) drive(0, 1, ADDR_W'(i + 1), 8'(i + 8'h70), 1, 2);
    drive(0, 0, 0, 8'h00, 0, 2);
    check("rst.pre_count", 32'(count), 32'd3);
    check("rst.pre_EscReg", 32'(EscReg), 32'd1);
    drive(1, 1, 4'd2, 8'hEE, 0, 3);
    check("rst.EscReg", 32'(EscReg), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.lookup_hit", 32'(lookup_hit), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 8'h00, 0, 3);
      check($sformatf("rst.quiet%0d", i), 32'(EscReg), 32'd0);
    end

    // Randomized traffic with a narrow register range so duplicates are common.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 249) == 0),
            ($urandom_range(0, 9) < 7),
            ADDR_W'($urandom_range(0, 5)),
            8'($urandom),
            ($urandom_range(0, 9) < 3),
            ADDR_W'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
